// File: rtl/blram_pkg.sv
// blram_pkg: shared types and defaults for the block RAM arbiter and its RAM.
package blram_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  localparam int BURST_W = 4;
  localparam logic REQ_IMEM = 1'b0;
  localparam logic REQ_DMEM = 1'b1;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;
endpackage

// File: rtl/blram_arbiter_if.sv
// blram_arbiter_if: requester ports plus the shared RAM port, named from the arbiter's side.
interface blram_arbiter_if
  import blram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          i_req0, i_we0, i_lock0;
  logic [AW-1:0] i_addr0;
  logic [DW-1:0] i_wdata0;
  logic          o_gnt0, o_rvalid0;
  logic [DW-1:0] o_rdata0;
  logic          i_req1, i_we1, i_lock1;
  logic [AW-1:0] i_addr1;
  logic [DW-1:0] i_wdata1;
  logic          o_gnt1, o_rvalid1;
  logic [DW-1:0] o_rdata1;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;
  modport slave (
    input  i_req0, i_we0, i_lock0, i_addr0, i_wdata0,
    output o_gnt0, o_rvalid0, o_rdata0,
    input  i_req1, i_we1, i_lock1, i_addr1, i_wdata1,
    output o_gnt1, o_rvalid1, o_rdata1,
    output o_ram_we, o_ram_addr, o_ram_wdata,
    input  i_ram_rdata
  );
  modport master (
    output i_req0, i_we0, i_lock0, i_addr0, i_wdata0,
    input  o_gnt0, o_rvalid0, o_rdata0,
    output i_req1, i_we1, i_lock1, i_addr1, i_wdata1,
    input  o_gnt1, o_rvalid1, o_rdata1,
    input  o_ram_we, o_ram_addr, o_ram_wdata,
    output i_ram_rdata
  );
endinterface

// File: rtl/blram_rd_return.sv
// blram_rd_return: per-requester read return; captures RAM data on the rvalid cycle and holds it.
module blram_rd_return
  import blram_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hit,
  input  logic [DW-1:0] ram_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] rdata_q, rdata_d;
  always_comb rdata_d = hit ? ram_rdata : rdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end
  assign rvalid = hit;
  assign rdata  = rdata_q;
endmodule

// File: rtl/blram_arbiter.sv
// blram_arbiter: round-robin/lock arbiter sharing one single-port block RAM between two requesters.
// Define BLRAM_ARB_FIXED_PRIO_EN to make requester 1 win every IDLE tie.
module blram_arbiter
  import blram_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  blram_arbiter_if.slave  bus
);
  localparam logic [BURST_W:0] BURST_LIM = (BURST_W + 1)'(MAX_BURST);
  arb_state_t         state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  rd_tag_t            tag_q, tag_d;
  logic               lock_hold, tie_win, win, any, win_lock, win_we;
  logic [BURST_W:0]   cnt_nxt;
  always_comb begin
    lock_hold = (state_q == LOCK0 && bus.i_req0) || (state_q == LOCK1 && bus.i_req1);
`ifdef BLRAM_ARB_FIXED_PRIO_EN
    tie_win = REQ_DMEM;
`else
    tie_win = ~last_gnt_q;
`endif
    any      = bus.i_req0 || bus.i_req1;
    win      = lock_hold ? (state_q == LOCK1) : (bus.i_req0 && bus.i_req1) ? tie_win : bus.i_req1;
    win_lock = win ? bus.i_lock1 : bus.i_lock0;
    win_we   = win ? bus.i_we1 : bus.i_we0;
    cnt_nxt  = {1'b0, burst_cnt_q} + 1'b1;
    bus.o_gnt0      = any && !win;
    bus.o_gnt1      = any && win;
    bus.o_ram_we    = any && win_we;
    bus.o_ram_addr  = any ? (win ? bus.i_addr1 : bus.i_addr0) : '0;
    bus.o_ram_wdata = any ? (win ? bus.i_wdata1 : bus.i_wdata0) : '0;
    tag_d       = '{valid: any && !win_we, owner: win};
    last_gnt_d  = any ? win : last_gnt_q;
    state_d     = IDLE;
    burst_cnt_d = '0;
    // A cycle where the lock owner is idle arbitrates like IDLE and may open a new lock.
    if (any && win_lock && MAX_BURST > 1) begin
      if (!lock_hold) begin
        state_d     = win ? LOCK1 : LOCK0;
        burst_cnt_d = BURST_W'(1);
      end else if (cnt_nxt < BURST_LIM) begin
        state_d     = state_q;
        burst_cnt_d = cnt_nxt[BURST_W-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      tag_q       <= tag_d;
    end
  end
  blram_rd_return #(.DW(DW)) u_rd0 (
    .clk       (clk),
    .rst       (rst),
    .hit       (tag_q.valid && tag_q.owner == REQ_IMEM),
    .ram_rdata (bus.i_ram_rdata),
    .rvalid    (bus.o_rvalid0),
    .rdata     (bus.o_rdata0)
  );
  blram_rd_return #(.DW(DW)) u_rd1 (
    .clk       (clk),
    .rst       (rst),
    .hit       (tag_q.valid && tag_q.owner == REQ_DMEM),
    .ram_rdata (bus.i_ram_rdata),
    .rvalid    (bus.o_rvalid1),
    .rdata     (bus.o_rdata1)
  );
endmodule

// File: tb/tb_blram_arbiter.sv
// tb_blram_arbiter: directed vector table plus reset, tie and burst sequences for blram_arbiter.
module tb_blram_arbiter;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] mem [1024];
  always #5 clk = ~clk;
  blram_arbiter_if #(.AW(10), .DW(32)) bus ();
  blram_arbiter #(.AW(10), .DW(32), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) begin
    if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
    bus.i_ram_rdata <= mem[bus.o_ram_addr];
  end
  typedef struct {
    logic r0, w0, l0; logic [9:0] a0;
    logic r1, w1, l1; logic [9:0] a1;
    logic g0, g1, rv0, rv1, rwe; logic [9:0] raddr;
    logic [31:0] rwd, rd0, rd1;
  } vec_t;
  vec_t tv [19];
`ifdef BLRAM_ARB_FIXED_PRIO_EN
  localparam logic [3:0] AG = 4'b0000;
  localparam logic [5:0] CG = 6'b000000;
`else
  localparam logic [3:0] AG = 4'b0101;
  localparam logic [5:0] CG = 6'b101111;
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic set_in(input logic r0, w0, l0, input logic [9:0] a0,
                        input logic r1, w1, l1, input logic [9:0] a1);
    bus.i_req0 = r0; bus.i_we0 = w0; bus.i_lock0 = l0; bus.i_addr0 = a0;
    bus.i_req1 = r1; bus.i_we1 = w1; bus.i_lock1 = l1; bus.i_addr1 = a1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    bus.i_wdata0 = 32'h0;
    bus.i_wdata1 = 32'hDEADBEEF;
    set_in(L, L, L, 10'h0, L, L, L, 10'h0);
    tv[0]  = '{H,L,L,10'h005, L,L,L,10'h000, H,L,L,L,L,10'h005, 32'h0,        32'h0,        32'h0};
    tv[1]  = '{L,L,L,10'h000, L,L,L,10'h000, L,L,H,L,L,10'h000, 32'h0,        32'h0,        32'h0};
    tv[2]  = '{L,L,L,10'h000, H,H,L,10'h3FF, L,H,L,L,H,10'h3FF, 32'hDEADBEEF, 32'hC0DE0005, 32'h0};
    tv[3]  = '{L,L,L,10'h000, H,L,L,10'h3FF, L,H,L,L,L,10'h3FF, 32'hDEADBEEF, 32'hC0DE0005, 32'h0};
    tv[4]  = '{L,L,L,10'h000, L,L,L,10'h000, L,L,L,H,L,10'h000, 32'h0,        32'hC0DE0005, 32'h0};
    tv[5]  = '{H,L,H,10'h010, L,L,L,10'h000, H,L,L,L,L,10'h010, 32'h0,        32'hC0DE0005, 32'hDEADBEEF};
    tv[6]  = '{H,L,H,10'h011, H,L,L,10'h020, H,L,H,L,L,10'h011, 32'h0,        32'hC0DE0005, 32'hDEADBEEF};
    tv[7]  = '{H,L,H,10'h012, H,L,L,10'h020, H,L,H,L,L,10'h012, 32'h0,        32'hC0DE0010, 32'hDEADBEEF};
    tv[8]  = '{H,L,H,10'h013, H,L,L,10'h020, H,L,H,L,L,10'h013, 32'h0,        32'hC0DE0011, 32'hDEADBEEF};
    tv[9]  = '{H,L,H,10'h014, H,L,L,10'h020, L,H,H,L,L,10'h020, 32'hDEADBEEF, 32'hC0DE0012, 32'hDEADBEEF};
    tv[10] = '{H,L,H,10'h014, L,L,L,10'h000, H,L,L,H,L,10'h014, 32'h0,        32'hC0DE0013, 32'hDEADBEEF};
    tv[11] = '{H,L,L,10'h015, H,L,L,10'h022, H,L,H,L,L,10'h015, 32'h0,        32'hC0DE0013, 32'hC0DE0020};
    tv[12] = '{H,L,H,10'h016, H,L,L,10'h022, L,H,H,L,L,10'h022, 32'hDEADBEEF, 32'hC0DE0014, 32'hC0DE0020};
    tv[13] = '{L,L,L,10'h000, L,L,L,10'h000, L,L,L,H,L,10'h000, 32'h0,        32'hC0DE0015, 32'hC0DE0020};
    tv[14] = '{L,L,L,10'h000, L,L,L,10'h000, L,L,L,L,L,10'h000, 32'h0,        32'hC0DE0015, 32'hC0DE0022};
    tv[15] = '{H,L,H,10'h030, L,L,L,10'h000, H,L,L,L,L,10'h030, 32'h0,        32'hC0DE0015, 32'hC0DE0022};
    tv[16] = '{L,L,L,10'h000, H,L,L,10'h031, L,H,H,L,L,10'h031, 32'hDEADBEEF, 32'hC0DE0015, 32'hC0DE0022};
    tv[17] = '{L,L,L,10'h000, L,L,L,10'h000, L,L,L,H,L,10'h000, 32'h0,        32'hC0DE0030, 32'hC0DE0022};
    tv[18] = '{L,L,L,10'h000, L,L,L,10'h000, L,L,L,L,L,10'h000, 32'h0,        32'hC0DE0030, 32'hC0DE0031};
    repeat (3) @(negedge clk);
    #1;
    chk("rst gnt0", 32'(bus.o_gnt0), 32'h0);
    chk("rst rvalid0", 32'(bus.o_rvalid0), 32'h0);
    chk("rst rvalid1", 32'(bus.o_rvalid1), 32'h0);
    chk("rst rdata0", bus.o_rdata0, 32'h0);
    chk("rst rdata1", bus.o_rdata1, 32'h0);
    chk("rst ram_we", 32'(bus.o_ram_we), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      set_in(tv[i].r0, tv[i].w0, tv[i].l0, tv[i].a0, tv[i].r1, tv[i].w1, tv[i].l1, tv[i].a1);
      #1;
      chk($sformatf("v%0d gnt0", i), 32'(bus.o_gnt0), 32'(tv[i].g0));
      chk($sformatf("v%0d gnt1", i), 32'(bus.o_gnt1), 32'(tv[i].g1));
      chk($sformatf("v%0d rvalid0", i), 32'(bus.o_rvalid0), 32'(tv[i].rv0));
      chk($sformatf("v%0d rvalid1", i), 32'(bus.o_rvalid1), 32'(tv[i].rv1));
      chk($sformatf("v%0d ram_we", i), 32'(bus.o_ram_we), 32'(tv[i].rwe));
      chk($sformatf("v%0d ram_addr", i), 32'(bus.o_ram_addr), 32'(tv[i].raddr));
      chk($sformatf("v%0d ram_wdata", i), bus.o_ram_wdata, tv[i].rwd);
      chk($sformatf("v%0d rdata0", i), bus.o_rdata0, tv[i].rd0);
      chk($sformatf("v%0d rdata1", i), bus.o_rdata1, tv[i].rd1);
    end
    // Reset while a requester-1 read is in flight: the return must be dropped.
    @(negedge clk);
    set_in(L, L, L, 10'h0, H, L, L, 10'h040);
    #1;
    chk("rstmid gnt1", 32'(bus.o_gnt1), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    set_in(L, L, L, 10'h0, L, L, L, 10'h0);
    #1;
    chk("rstmid rvalid1", 32'(bus.o_rvalid1), 32'h0);
    chk("rstmid rdata1", bus.o_rdata1, 32'h0);
    @(negedge clk);
    #1;
    chk("rstmid rvalid1 held", 32'(bus.o_rvalid1), 32'h0);
    rst = 1'b1;
    // Continuous tie straight after reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) set_in(H, L, L, 10'(10'h050 + k), H, L, L, 10'(10'h060 + k));
      else       set_in(L, L, L, 10'h0, L, L, L, 10'h0);
      #1;
      if (k < 4) begin
        chk($sformatf("tie%0d gnt0", k), 32'(bus.o_gnt0), 32'(AG[k]));
        chk($sformatf("tie%0d gnt1", k), 32'(bus.o_gnt1), 32'(!AG[k]));
      end
      if (k > 0) begin
        chk($sformatf("tie%0d rvalid0", k), 32'(bus.o_rvalid0), 32'(AG[k-1]));
        chk($sformatf("tie%0d rvalid1", k), 32'(bus.o_rvalid1), 32'(!AG[k-1]));
      end
    end
    // Lock burst with requester 1 waiting throughout.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      set_in(H, L, H, 10'h070, H, L, L, 10'h071);
      #1;
      chk($sformatf("burst%0d gnt0", k), 32'(bus.o_gnt0), 32'(CG[k]));
      chk($sformatf("burst%0d gnt1", k), 32'(bus.o_gnt1), 32'(!CG[k]));
      chk($sformatf("burst%0d ram_addr", k), 32'(bus.o_ram_addr), CG[k] ? 32'h070 : 32'h071);
    end
    @(negedge clk);
    set_in(L, L, L, 10'h0, L, L, L, 10'h0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
